// File: rtl/sisc_pkg.sv
// Shared types and constants for the instruction fetch queue.
package sisc_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } ifq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush and a registered head that holds its last value when empty.
module ifq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_rd_next;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic [WIDTH-1:0] r_head;
  logic             w_push;
  logic             w_pop;

  assign o_full       = (r_count == FULL_CNT);
  assign o_empty      = (r_count == '0);
  assign o_count      = r_count;
  assign o_head       = r_head;
  assign w_push       = i_push & ~o_full & ~i_flush;
  assign w_pop        = i_pop & ~o_empty & ~i_flush;
  assign w_rd_next    = r_rd_ptr + PW'(w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      // Write slot equals next read slot only when the pushed word becomes the head.
      if (w_count_next != '0) begin
        r_head <= (w_push && (r_wr_ptr == w_rd_next)) ? i_data : r_mem[w_rd_next];
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, requests instruction memory, queues tagged words for decode.
// Optional IFQ_BYPASS_EN forwards an acked word straight to decode when the queue is empty.
module ifetch_queue #(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_addr,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   instr_valid,
  output logic [DATA_W-1:0]      instr,
  output logic [ADDR_W-1:0]      instr_pc,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] q_count
);

  import sisc_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  ifq_state_t        r_state;
  ifq_state_t        w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_fetch_pc_next;
  logic [ADDR_W-1:0] r_target;
  logic [ADDR_W-1:0] w_target_next;
  logic              w_accept;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_next;
  logic [EW-1:0]     w_head;

  assign mem_req      = (r_state != IDLE);
  assign mem_addr     = r_fetch_pc;
  assign q_count      = w_count;
  assign w_accept     = (r_state == REQ) & mem_ack & ~redirect;
  // Flush takes priority over a same-cycle pop.
  assign w_fifo_pop   = ~w_fifo_empty & instr_ready & ~redirect;
  assign w_count_next = w_count + CW'(w_fifo_push) - CW'(w_fifo_pop);

`ifdef IFQ_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = w_fifo_empty & w_accept;
  assign w_fifo_push = w_accept & ~w_fifo_full & ~(w_bypass & instr_ready);
  assign instr_valid = ~w_fifo_empty | w_bypass;
  assign instr       = w_bypass ? mem_data : w_head[DATA_W-1:0];
  assign instr_pc    = w_bypass ? mem_addr : w_head[EW-1:DATA_W];
`else
  assign w_fifo_push = w_accept & ~w_fifo_full;
  assign instr_valid = ~w_fifo_empty;
  assign instr       = w_head[DATA_W-1:0];
  assign instr_pc    = w_head[EW-1:DATA_W];
`endif

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_fifo_push),
    .i_data  ({r_fetch_pc, mem_data}),
    .i_pop   (w_fifo_pop),
    .i_flush (redirect),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_target_next   = r_target;
    if (redirect) begin
      // An outstanding request keeps its address until acked; the target waits in r_target.
      if (r_state != IDLE && !mem_ack) begin
        w_target_next = redirect_addr;
        w_state_next  = DROP;
      end else begin
        w_fetch_pc_next = redirect_addr;
        w_state_next    = REQ;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_count_next < FULL_CNT) begin
            w_state_next = REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            w_fetch_pc_next = r_fetch_pc + ADDR_W'(1);
            w_state_next    = (w_count_next < FULL_CNT) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (mem_ack) begin
            w_fetch_pc_next = r_target;
            w_state_next    = REQ;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_target   <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_target   <= w_target_next;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (default build, one-cycle ack-to-valid latency).
module tb_ifetch_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  // Memory returns a tag plus the requested address.
  assign mem_data = {16'hC0DE, mem_addr};

  ifetch_queue #(
    .DEPTH    (4),
    .ADDR_W   (16),
    .DATA_W   (32),
    .RESET_PC (16'h0000)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .q_count       (q_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'h0000);
    check({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, " instr"}, instr, 32'h0);
    check({tag, " instr_pc"}, 32'(instr_pc), 32'h0);
    check({tag, " q_count"}, 32'(q_count), 32'd0);
  endtask

  initial begin
    logic [15:0] wrap_pc [4];
    wrap_pc[0] = 16'hFFFE;
    wrap_pc[1] = 16'hFFFF;
    wrap_pc[2] = 16'h0000;
    wrap_pc[3] = 16'h0001;

    // Streaming with ack tied high and decode always ready.
    RST = 1'b1; redirect = 1'b0; redirect_addr = '0; mem_ack = 1'b1; instr_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    step();
    RST = 1'b0;
    step();
    check("stream first req", 32'(mem_req), 32'd1);
    check("stream first addr", 32'(mem_addr), 32'h0000);
    check("stream first valid", 32'(instr_valid), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("stream addr", 32'(mem_addr), 32'(i));
      check("stream valid", 32'(instr_valid), 32'd1);
      check("stream pc", 32'(instr_pc), 32'(i - 1));
      check("stream instr", instr, {16'hC0DE, 16'(i - 1)});
      check("stream count", 32'(q_count), 32'd1);
    end

    // Fill to full with decode stalled, then free one slot.
    RST = 1'b1;
    #1;
    instr_ready = 1'b0;
    step();
    RST = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      check("fill count", 32'(q_count), 32'(k));
    end
    check("full req", 32'(mem_req), 32'd0);
    check("full head pc", 32'(instr_pc), 32'h0000);
    step();
    check("full stays idle", 32'(mem_req), 32'd0);
    check("full stays count", 32'(q_count), 32'd4);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("refill req", 32'(mem_req), 32'd1);
    check("refill addr", 32'(mem_addr), 32'h0004);
    check("refill count", 32'(q_count), 32'd3);
    check("refill head pc", 32'(instr_pc), 32'h0001);

    // Redirect while a request is outstanding: old address held, its data dropped.
    mem_ack = 1'b0;
    redirect = 1'b1;
    redirect_addr = 16'h0040;
    step();
    redirect = 1'b0;
    check("drop req", 32'(mem_req), 32'd1);
    check("drop addr held", 32'(mem_addr), 32'h0004);
    check("drop flushed valid", 32'(instr_valid), 32'd0);
    check("drop flushed count", 32'(q_count), 32'd0);
    step();
    check("drop addr held 2", 32'(mem_addr), 32'h0004);
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    step();
    check("drop new addr", 32'(mem_addr), 32'h0040);
    check("drop data discarded", 32'(instr_valid), 32'd0);
    step();
    check("drop first pc", 32'(instr_pc), 32'h0040);
    check("drop first instr", instr, 32'hC0DE_0040);
    check("drop next addr", 32'(mem_addr), 32'h0041);

    // Redirect coincident with an ack while two entries are queued.
    instr_ready = 1'b0;
    step();
    check("queued two", 32'(q_count), 32'd2);
    redirect = 1'b1;
    redirect_addr = 16'h0100;
    step();
    redirect = 1'b0;
    instr_ready = 1'b1;
    check("ack redir valid", 32'(instr_valid), 32'd0);
    check("ack redir count", 32'(q_count), 32'd0);
    check("ack redir addr", 32'(mem_addr), 32'h0100);
    step();
    check("ack redir pc", 32'(instr_pc), 32'h0100);
    check("ack redir instr", instr, 32'hC0DE_0100);

    // PC wraparound.
    redirect = 1'b1;
    redirect_addr = 16'hFFFE;
    step();
    redirect = 1'b0;
    check("wrap addr", 32'(mem_addr), 32'hFFFE);
    for (int i = 0; i < 4; i++) begin
      step();
      check("wrap pc", 32'(instr_pc), 32'(wrap_pc[i]));
      check("wrap valid", 32'(instr_valid), 32'd1);
    end
    check("wrap next addr", 32'(mem_addr), 32'h0002);

    // Reset in the middle of DROP.
    mem_ack = 1'b0;
    redirect = 1'b1;
    redirect_addr = 16'h0200;
    step();
    redirect = 1'b0;
    check("pre-reset drop req", 32'(mem_req), 32'd1);
    check("pre-reset drop addr", 32'(mem_addr), 32'h0002);
    RST = 1'b1;
    #1;
    check_reset_outputs("async reset");
    step();
    RST = 1'b0;
    mem_ack = 1'b1;
    step();
    check("post-reset req", 32'(mem_req), 32'd1);
    check("post-reset addr", 32'(mem_addr), 32'h0000);
    step();
    check("post-reset pc", 32'(instr_pc), 32'h0000);
    check("post-reset valid", 32'(instr_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch stage that sits upstream of the decoder/ctrl and downstream of instruction memory.
- Owns the fetch PC and issues word-addressed requests to the instruction memory through a req/ack handshake.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and presents them to decode through a valid/ready handshake.
- Taken branches arrive as a redirect: it flushes the queue and discards any in-flight response.

Parameters:
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2
ADDR_W, 16, width of the PC / instruction address
DATA_W, 32, width of an instruction word
RESET_PC, 16'h0000, fetch address loaded on reset

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  asynchronous reset, active-high
redirect  in  1  branch taken; flush and refetch from redirect_addr
redirect_addr  in  ADDR_W  new fetch address, sampled when redirect=1
mem_req  out  1  fetch request to instruction memory
mem_addr  out  ADDR_W  fetch address; stable while mem_req=1 and mem_ack=0
mem_ack  in  1  memory accepts the request; mem_data is valid in the same cycle
mem_data  in  DATA_W  returned instruction word
instr_valid  out  1  queue head is valid
instr  out  DATA_W  queue head instruction
instr_pc  out  ADDR_W  PC of the queue head
instr_ready  in  1  decode consumes the head (pop = instr_valid & instr_ready)
q_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, fetch_pc=RESET_PC, FIFO pointers and count cleared.
  - mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, q_count=0.
  - Reset asserted mid-request abandons the request with no drain.
- FSM states: IDLE, REQ, DROP. All outputs are registered or decoded from state; mem_req=1 exactly in REQ and DROP.
- IDLE:
  - Go to REQ next cycle if count<DEPTH.
  - First request is therefore issued one cycle after reset deassertion.
- REQ: mem_addr=fetch_pc.
  - On mem_ack with no redirect: push {fetch_pc, mem_data}; fetch_pc <= fetch_pc+1 (wraps 16'hFFFF->16'h0000).
  - After the push, stay in REQ if count_next<DEPTH, else go to IDLE.
  - count_next = count + push - pop.
  - Back-to-back acks give 1 instruction per cycle.
- DROP: a redirect arrived while a request was outstanding.
  - mem_req stays 1 with the old mem_addr until mem_ack; the ack's data is discarded.
  - Then go to REQ with fetch_pc = the latched redirect_addr.
- Redirect, in any state:
  - FIFO flushed (count=0, instr_valid=0 next cycle); redirect_addr latched into fetch_pc.
  - From REQ with mem_ack=0: go to DROP.
  - From REQ with mem_ack=1 in the same cycle: ack data discarded; go to REQ at redirect_addr.
  - From IDLE: go to REQ at redirect_addr.
  - From DROP: replace the latched target; still wait for the ack.
- Redirect plus pop in the same cycle: flush wins; the pop has no further effect.
- Full (count=DEPTH): no request is issued, so a push can never occur while full. Pop with no push frees a slot; REQ is re-entered the next cycle.
- Empty: instr_valid=0; instr and instr_pc hold their last values.
- Latency: mem_ack to instr_valid is 1 cycle.
- FIFO: read/write pointers of $clog2(DEPTH) bits wrapping mod DEPTH. Simultaneous push and pop leave count unchanged.

Optional Feature:
IFQ_BYPASS_EN:
- Defined: when the FIFO is empty, state is REQ, mem_ack=1 and redirect=0, then mem_data/mem_addr drive instr/instr_pc combinationally and instr_valid=1 in the same cycle. If instr_ready=1, the word is not written to the FIFO. Latency becomes 0 cycles.
- Undefined: no combinational path from the mem_* inputs to the instr_* outputs; latency is 1 cycle.

Decomposition:
- sisc_pkg holds:
  - constants WORD_W=32 and ADDR_W=16;
  - typedef enum ifq_state_t {IDLE, REQ, DROP};
  - typedef struct ifq_entry_t {pc, instr}.
- One sub-module, ifq_fifo: a synchronous DEPTH-entry FIFO with push/pop/flush inputs and full/empty/count outputs. It is instantiated once; the FSM and fetch_pc stay in ifetch_queue.

Test Plan:
- Reset release, mem_ack tied 1, instr_ready=1 -> mem_addr 0,1,2,3 on consecutive cycles; instr_pc 0,1,2 follows with 1-cycle lag; q_count <=1.
- instr_ready=0, mem_ack=1 -> exactly 4 pushes (PC 0-3), then mem_req=0 and q_count=4. Pulse instr_ready for 1 cycle -> next cycle mem_req=1 with mem_addr=4.
- mem_ack delayed 3 cycles, redirect to 16'h0040 in the first of those cycles -> mem_addr stays at the old value until ack; that data never appears on instr; next request is at 16'h0040.
- redirect to 16'h0100 in the same cycle as mem_ack, with 2 entries queued -> instr_valid=0 next cycle; next mem_addr=16'h0100; the acked word is discarded.
- redirect_addr=16'hFFFE, acks every cycle -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- RST asserted mid-DROP -> outputs immediately at reset values; after release, first mem_addr=RESET_PC.
